// File: rtl/k10_imm_stage.sv
// ---------------------------------------------------------------------------
// k10_imm_stage
//   Registered immediate-extraction stage sitting between fetch and decode.
//   Each accepted instruction is classified (I/S/B/U/J/ZIMM/RVC/NONE), its
//   immediate is extracted and extended to XLEN, and the result is queued
//   with a pass-through tag in a 2-entry skid buffer.
//
// Parameters
//   XLEN    immediate width (32 or 64)
//   RVC_EN  1 = decode the supported compressed subset, 0 = compressed -> NONE
//   TAG_W   sideband tag width
//
// Ports
//   i_clk, i_rst_n            clock, asynchronous active-low reset
//   i_flush                   drop all buffered entries and any same-cycle push
//   i_valid / o_in_ready      input handshake; o_in_ready is registered (count<2)
//   i_instr, i_tag            raw instruction (compressed form in [15:0]), tag
//   o_out_valid / i_out_ready output handshake for the head entry
//   o_imm, o_fmt, o_tag       head entry immediate, format code, tag
// ---------------------------------------------------------------------------
package k10_imm_pkg;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;

   typedef enum logic [2:0] {
      FMT_NONE = 3'd0,
      FMT_I    = 3'd1,
      FMT_S    = 3'd2,
      FMT_B    = 3'd3,
      FMT_U    = 3'd4,
      FMT_J    = 3'd5,
      FMT_ZIMM = 3'd6,
      FMT_C    = 3'd7
   } fmt_e;
endpackage

module k10_imm_stage
   import k10_imm_pkg::*;
#(
   parameter int unsigned XLEN   = 32,
   parameter int unsigned RVC_EN = 1,
   parameter int unsigned TAG_W  = 32
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_flush,
   input  logic             i_valid,
   output logic             o_in_ready,
   input  logic [31:0]      i_instr,
   input  logic [TAG_W-1:0] i_tag,
   output logic             o_out_valid,
   input  logic             i_out_ready,
   output logic [XLEN-1:0]  o_imm,
   output logic [2:0]       o_fmt,
   output logic [TAG_W-1:0] o_tag
);

   logic [XLEN-1:0]  w_imm;
   fmt_e             w_fmt;
   logic             w_push;
   logic             w_pop;
   logic [1:0]       w_count_nxt;

   logic [XLEN-1:0]  r_imm [2];
   logic [2:0]       r_fmt [2];
   logic [TAG_W-1:0] r_tag [2];
   logic [1:0]       r_count;
   logic             r_wr_ptr;
   logic             r_rd_ptr;
   logic             r_in_ready;

   // Immediate extraction; signed size casts perform the sign extension.
   always_comb begin
      w_imm = '0;
      w_fmt = FMT_NONE;
      if (i_instr[1:0] == 2'b11) begin
         case (i_instr[6:0])
            OP_IMM, OP_LOAD, OP_JALR: begin
               w_fmt = FMT_I;
               w_imm = XLEN'($signed(i_instr[31:20]));
            end
            OP_STORE: begin
               w_fmt = FMT_S;
               w_imm = XLEN'($signed({i_instr[31:25], i_instr[11:7]}));
            end
            OP_BRANCH: begin
               w_fmt = FMT_B;
               w_imm = XLEN'($signed({i_instr[31], i_instr[7], i_instr[30:25],
                                      i_instr[11:8], 1'b0}));
            end
            OP_LUI, OP_AUIPC: begin
               w_fmt = FMT_U;
               w_imm = XLEN'($signed({i_instr[31:12], 12'h000}));
            end
            OP_JAL: begin
               w_fmt = FMT_J;
               w_imm = XLEN'($signed({i_instr[31], i_instr[19:12], i_instr[20],
                                      i_instr[30:21], 1'b0}));
            end
            OP_SYSTEM: begin
               w_fmt = FMT_ZIMM;
               w_imm = XLEN'(i_instr[19:15]);
            end
            default: ;
         endcase
      end else if (RVC_EN != 0) begin
         // Keyed on {funct3, quadrant}.
         case ({i_instr[15:13], i_instr[1:0]})
            5'b000_01, 5'b010_01: begin
               w_fmt = FMT_C;
               w_imm = XLEN'($signed({i_instr[12], i_instr[6:2]}));
            end
            5'b011_01: begin
               w_fmt = FMT_C;
               if (i_instr[11:7] == 5'd2)
                  w_imm = XLEN'($signed({i_instr[12], i_instr[4:3], i_instr[5],
                                         i_instr[2], i_instr[6], 4'h0}));
               else
                  w_imm = XLEN'($signed({i_instr[12], i_instr[6:2], 12'h000}));
            end
            5'b101_01: begin
               w_fmt = FMT_C;
               w_imm = XLEN'($signed({i_instr[12], i_instr[8], i_instr[10:9],
                                      i_instr[6], i_instr[7], i_instr[2],
                                      i_instr[11], i_instr[5:3], 1'b0}));
            end
            5'b110_01, 5'b111_01: begin
               w_fmt = FMT_C;
               w_imm = XLEN'($signed({i_instr[12], i_instr[6:5], i_instr[2],
                                      i_instr[11:10], i_instr[4:3], 1'b0}));
            end
            5'b010_00, 5'b110_00: begin
               w_fmt = FMT_C;
               w_imm = XLEN'({i_instr[5], i_instr[12:10], i_instr[6], 2'b00});
            end
            5'b010_10: begin
               w_fmt = FMT_C;
               w_imm = XLEN'({i_instr[3:2], i_instr[12], i_instr[6:4], 2'b00});
            end
            5'b110_10: begin
               w_fmt = FMT_C;
               w_imm = XLEN'({i_instr[8:7], i_instr[12:9], 2'b00});
            end
            default: ;
         endcase
      end
   end

   assign w_push = i_valid & r_in_ready;
   assign w_pop  = (r_count != 2'd0) & i_out_ready;

   always_comb begin
      w_count_nxt = r_count;
      case ({w_push, w_pop})
         2'b10:   w_count_nxt = r_count + 2'd1;
         2'b01:   w_count_nxt = r_count - 2'd1;
         default: w_count_nxt = r_count;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int unsigned k = 0; k < 2; k++) begin
            r_imm[k] <= '0;
            r_fmt[k] <= '0;
            r_tag[k] <= '0;
         end
         r_count    <= '0;
         r_wr_ptr   <= 1'b0;
         r_rd_ptr   <= 1'b0;
         r_in_ready <= 1'b1;
      end else if (i_flush) begin
         r_count    <= '0;
         r_wr_ptr   <= 1'b0;
         r_rd_ptr   <= 1'b0;
         r_in_ready <= 1'b1;
      end else begin
         if (w_push) begin
            r_imm[r_wr_ptr] <= w_imm;
            r_fmt[r_wr_ptr] <= w_fmt;
            r_tag[r_wr_ptr] <= i_tag;
            r_wr_ptr        <= ~r_wr_ptr;
         end
         if (w_pop)
            r_rd_ptr <= ~r_rd_ptr;
         r_count    <= w_count_nxt;
         // Registered ready derived from the next count, so it always equals count<2.
         r_in_ready <= (w_count_nxt != 2'd2);
      end
   end

   assign o_in_ready  = r_in_ready;
   assign o_out_valid = (r_count != 2'd0);
   assign o_imm       = r_imm[r_rd_ptr];
   assign o_fmt       = r_fmt[r_rd_ptr];
   assign o_tag       = r_tag[r_rd_ptr];

endmodule

// File: tb/tb_k10_imm_stage.sv
module tb_k10_imm_stage;

   logic        clk;
   logic        i_rst_n;
   logic        i_flush;
   logic        i_valid;
   logic [31:0] i_instr;
   logic [31:0] i_tag;
   logic        i_out_ready;

   logic        rdy_a, vld_a, rdy_b, vld_b, rdy_c, vld_c;
   logic [31:0] imm_a, imm_c;
   logic [63:0] imm_b;
   logic [2:0]  fmt_a, fmt_b, fmt_c;
   logic [31:0] tag_a, tag_b, tag_c;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      logic [31:0] ins;
      logic [31:0] tag;
   } ent_t;

   ent_t q[$];
   ent_t m_ent;
   bit   m_push, m_pop, m_fl;

   k10_imm_stage #(.XLEN(32), .RVC_EN(1), .TAG_W(32)) u_dut32 (
      .i_clk(clk), .i_rst_n(i_rst_n), .i_flush(i_flush), .i_valid(i_valid),
      .o_in_ready(rdy_a), .i_instr(i_instr), .i_tag(i_tag), .o_out_valid(vld_a),
      .i_out_ready(i_out_ready), .o_imm(imm_a), .o_fmt(fmt_a), .o_tag(tag_a));

   k10_imm_stage #(.XLEN(64), .RVC_EN(1), .TAG_W(32)) u_dut64 (
      .i_clk(clk), .i_rst_n(i_rst_n), .i_flush(i_flush), .i_valid(i_valid),
      .o_in_ready(rdy_b), .i_instr(i_instr), .i_tag(i_tag), .o_out_valid(vld_b),
      .i_out_ready(i_out_ready), .o_imm(imm_b), .o_fmt(fmt_b), .o_tag(tag_b));

   k10_imm_stage #(.XLEN(32), .RVC_EN(0), .TAG_W(32)) u_norvc (
      .i_clk(clk), .i_rst_n(i_rst_n), .i_flush(i_flush), .i_valid(i_valid),
      .o_in_ready(rdy_c), .i_instr(i_instr), .i_tag(i_tag), .o_out_valid(vld_c),
      .i_out_ready(i_out_ready), .o_imm(imm_c), .o_fmt(fmt_c), .o_tag(tag_c));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   function automatic longint fld(input logic [31:0] x, input int hi, input int lo);
      longint v = longint'(x);
      return (v >> lo) & ((longint'(1) << (hi - lo + 1)) - 1);
   endfunction

   function automatic longint sx(input longint v, input int n);
      if (((v >> (n - 1)) & 1) != 0) return v - (longint'(1) << n);
      return v;
   endfunction

   function automatic void ref_imm(input logic [31:0] ins, input bit rvc,
                                   output logic [63:0] imm, output logic [2:0] fmt);
      longint r = 0;
      longint key;
      fmt = 3'd0;
      if (fld(ins, 1, 0) == 3) begin
         case (fld(ins, 6, 0))
            'h13, 'h03, 'h67: begin fmt = 3'd1; r = sx(fld(ins, 31, 20), 12); end
            'h23: begin fmt = 3'd2; r = sx(fld(ins, 31, 25) * 32 + fld(ins, 11, 7), 12); end
            'h63: begin
               fmt = 3'd3;
               r = sx(fld(ins, 31, 31) * 4096 + fld(ins, 7, 7) * 2048 +
                      fld(ins, 30, 25) * 32 + fld(ins, 11, 8) * 2, 13);
            end
            'h37, 'h17: begin fmt = 3'd4; r = sx(fld(ins, 31, 12) * 4096, 32); end
            'h6F: begin
               fmt = 3'd5;
               r = sx(fld(ins, 31, 31) * (1 << 20) + fld(ins, 19, 12) * 4096 +
                      fld(ins, 20, 20) * 2048 + fld(ins, 30, 21) * 2, 21);
            end
            'h73: begin fmt = 3'd6; r = fld(ins, 19, 15); end
            default: ;
         endcase
      end else if (rvc) begin
         key = fld(ins, 15, 13) * 4 + fld(ins, 1, 0);
         fmt = 3'd7;
         case (key)
            1, 9: r = sx(fld(ins, 12, 12) * 32 + fld(ins, 6, 2), 6);
            13: begin
               if (fld(ins, 11, 7) == 2)
                  r = sx(fld(ins, 12, 12) * 512 + fld(ins, 4, 3) * 128 + fld(ins, 5, 5) * 64 +
                         fld(ins, 2, 2) * 32 + fld(ins, 6, 6) * 16, 10);
               else
                  r = sx((fld(ins, 12, 12) * 32 + fld(ins, 6, 2)) * 4096, 18);
            end
            21: r = sx(fld(ins, 12, 12) * 2048 + fld(ins, 8, 8) * 1024 + fld(ins, 10, 9) * 256 +
                       fld(ins, 6, 6) * 128 + fld(ins, 7, 7) * 64 + fld(ins, 2, 2) * 32 +
                       fld(ins, 11, 11) * 16 + fld(ins, 5, 3) * 2, 12);
            25, 29: r = sx(fld(ins, 12, 12) * 256 + fld(ins, 6, 5) * 64 + fld(ins, 2, 2) * 32 +
                           fld(ins, 11, 10) * 8 + fld(ins, 4, 3) * 2, 9);
            8, 24: r = fld(ins, 5, 5) * 64 + fld(ins, 12, 10) * 8 + fld(ins, 6, 6) * 4;
            10: r = fld(ins, 3, 2) * 64 + fld(ins, 12, 12) * 32 + fld(ins, 6, 4) * 4;
            26: r = fld(ins, 8, 7) * 64 + fld(ins, 12, 9) * 4;
            default: begin fmt = 3'd0; r = 0; end
         endcase
      end
      imm = 64'(r);
   endfunction

   // ---------------- checking ----------------
   task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%h expected=%h", name, obs, exp);
      end
   endtask

   task automatic check_all();
      logic [63:0] e_imm;
      logic [2:0]  e_fmt;
      logic        has;
      has = (q.size() != 0);
      chk("valid32", 64'(vld_a), 64'(has));
      chk("ready32", 64'(rdy_a), 64'(q.size() < 2));
      chk("valid64", 64'(vld_b), 64'(has));
      chk("ready64", 64'(rdy_b), 64'(q.size() < 2));
      chk("validnc", 64'(vld_c), 64'(has));
      chk("readync", 64'(rdy_c), 64'(q.size() < 2));
      if (has) begin
         ref_imm(q[0].ins, 1'b1, e_imm, e_fmt);
         chk("imm32", 64'(imm_a), {32'h0, e_imm[31:0]});
         chk("fmt32", 64'(fmt_a), 64'(e_fmt));
         chk("tag32", 64'(tag_a), 64'(q[0].tag));
         chk("imm64", imm_b, e_imm);
         chk("fmt64", 64'(fmt_b), 64'(e_fmt));
         chk("tag64", 64'(tag_b), 64'(q[0].tag));
         ref_imm(q[0].ins, 1'b0, e_imm, e_fmt);
         chk("immnc", 64'(imm_c), {32'h0, e_imm[31:0]});
         chk("fmtnc", 64'(fmt_c), 64'(e_fmt));
         chk("tagnc", 64'(tag_c), 64'(q[0].tag));
      end
   endtask

   task automatic zero_chk(input string name);
      chk({name, "_valid"}, 64'({vld_a, vld_b, vld_c}), 64'd0);
      chk({name, "_ready"}, 64'({rdy_a, rdy_b, rdy_c}), 64'd7);
      chk({name, "_imm"}, 64'(imm_a) | imm_b | 64'(imm_c), 64'd0);
      chk({name, "_fmt"}, 64'({fmt_a, fmt_b, fmt_c}), 64'd0);
      chk({name, "_tag"}, 64'(tag_a) | 64'(tag_b) | 64'(tag_c), 64'd0);
   endtask

   // Drive one cycle's inputs at the falling edge, check, and record the model action.
   task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] tg,
                        input logic ordy, input logic fl);
      @(negedge clk);
      i_valid = v; i_instr = ins; i_tag = tg; i_out_ready = ordy; i_flush = fl;
      #1;
      check_all();
      m_push = v && (q.size() < 2) && !fl;
      m_pop  = ordy && (q.size() != 0) && !fl;
      m_fl   = fl;
      m_ent  = '{ins, tg};
   endtask

   task automatic commit();
      @(posedge clk);
      if (m_fl) q.delete();
      else begin
         if (m_pop) void'(q.pop_front());
         if (m_push) q.push_back(m_ent);
      end
   endtask

   task automatic directed(input logic [31:0] ins, input logic [31:0] tg,
                           input logic [31:0] e32, input logic [2:0] f32,
                           input logic [63:0] e64, input logic [31:0] enc, input logic [2:0] fnc);
      drive(1'b1, ins, tg, 1'b1, 1'b0);
      commit();
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      chk("dir_valid", 64'(vld_a), 64'd1);
      chk("dir_imm32", 64'(imm_a), 64'(e32));
      chk("dir_fmt32", 64'(fmt_a), 64'(f32));
      chk("dir_imm64", imm_b, e64);
      chk("dir_immnc", 64'(imm_c), 64'(enc));
      chk("dir_fmtnc", 64'(fmt_c), 64'(fnc));
      commit();
   endtask

   function automatic logic [31:0] rnd_instr();
      logic [6:0]  ops [11] = '{7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37,
                                7'h17, 7'h6F, 7'h73, 7'h33, 7'h0F};
      logic [31:0] x;
      int unsigned sel;
      x   = $urandom;
      sel = $urandom_range(0, 4);
      if (sel < 2) x[6:0] = ops[$urandom_range(0, 10)];
      else if (sel < 4) x[1:0] = 2'($urandom_range(0, 2));
      return x;
   endfunction

   initial begin
      i_rst_n = 1'b0; i_flush = 1'b0; i_valid = 1'b0;
      i_instr = '0; i_tag = '0; i_out_ready = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      zero_chk("reset");
      i_rst_n = 1'b1;

      // Directed extraction cases
      directed(32'hFFF00093, 32'h100, 32'hFFFFFFFF, 3'd1, 64'hFFFFFFFFFFFFFFFF, 32'hFFFFFFFF, 3'd1);
      directed(32'hFE000EE3, 32'h101, 32'hFFFFFFFC, 3'd3, 64'hFFFFFFFFFFFFFFFC, 32'hFFFFFFFC, 3'd3);
      directed(32'h7C0FD073, 32'h102, 32'h0000001F, 3'd6, 64'h000000000000001F, 32'h0000001F, 3'd6);
      directed(32'h000050FD, 32'h103, 32'hFFFFFFFF, 3'd7, 64'hFFFFFFFFFFFFFFFF, 32'h00000000, 3'd0);
      directed(32'h80000037, 32'h104, 32'h80000000, 3'd4, 64'hFFFFFFFF80000000, 32'h80000000, 3'd4);
      directed(32'h0000717D, 32'h105, 32'hFFFFFFF0, 3'd7, 64'hFFFFFFFFFFFFFFF0, 32'h00000000, 3'd0);

      // Backpressure: tags 1,2,3 offered back to back with the consumer stalled
      drive(1'b1, 32'h00100093, 32'd1, 1'b0, 1'b0); commit();
      drive(1'b1, 32'h00200093, 32'd2, 1'b0, 1'b0); commit();
      drive(1'b1, 32'h00300093, 32'd3, 1'b0, 1'b0);
      chk("bp_full_ready", 64'(rdy_a), 64'd0);
      chk("bp_hold_tag", 64'(tag_a), 64'd1);
      commit();
      drive(1'b1, 32'h00300093, 32'd3, 1'b0, 1'b0);
      chk("bp_stable_tag", 64'(tag_a), 64'd1);
      chk("bp_stable_imm", 64'(imm_a), 64'd1);
      commit();
      drive(1'b1, 32'h00300093, 32'd3, 1'b1, 1'b0);
      chk("bp_out1", 64'(tag_a), 64'd1);
      commit();
      drive(1'b1, 32'h00300093, 32'd3, 1'b1, 1'b0);
      chk("bp_out2", 64'(tag_a), 64'd2);
      commit();
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      chk("bp_out3", 64'(tag_a), 64'd3);
      commit();

      // Flush at count=2 together with a push
      drive(1'b1, 32'h00A00093, 32'd10, 1'b0, 1'b0); commit();
      drive(1'b1, 32'h00B00093, 32'd11, 1'b0, 1'b0); commit();
      drive(1'b1, 32'h00C00093, 32'd12, 1'b1, 1'b1); commit();
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      chk("flush_valid", 64'(vld_a), 64'd0);
      chk("flush_ready", 64'(rdy_a), 64'd1);
      commit();
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      chk("flush_empty", 64'(vld_a), 64'd0);
      commit();

      // Randomized traffic with occasional flush
      for (int i = 0; i < 400; i++) begin
         drive(($urandom % 4) != 0, rnd_instr(), $urandom, ($urandom % 3) != 0,
               ($urandom % 40) == 0);
         commit();
      end

      // Asynchronous reset mid-stream
      drive(1'b1, 32'h12345013, 32'hAA, 1'b0, 1'b0); commit();
      drive(1'b1, 32'h00F12023, 32'hBB, 1'b0, 1'b0); commit();
      @(negedge clk);
      i_valid = 1'b1;
      #2 i_rst_n = 1'b0;
      #1 zero_chk("midrst");
      q.delete();
      @(negedge clk);
      i_valid = 1'b0;
      i_rst_n = 1'b1;
      for (int i = 0; i < 40; i++) begin
         drive(($urandom % 2) != 0, rnd_instr(), $urandom, ($urandom % 2) != 0, 1'b0);
         commit();
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
